// File: rtl/serial_sub_if.sv
// Handshake bundle for the bit-serial subtractor: operand side (A, B, Bin)
// and result side (D, Bout, ovf), each with its own valid/ready pair.
interface serial_sub_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             ovf;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, Bout, ovf
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, Bout, ovf
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first,
// through a single registered borrow stage. All outputs are registered.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One full-subtractor bit: {borrow_next, difference}
    function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic br);
        sub_bit = {(~a & b) | (~(a ^ b) & br), a ^ b ^ br};
    endfunction

    state_t           state_r,     state_s;
    logic [WIDTH-1:0] a_sr_r,      a_sr_s;
    logic [WIDTH-1:0] b_sr_r,      b_sr_s;
    logic [WIDTH-1:0] res_sr_r,    res_sr_s;
    logic             borrow_r,    borrow_s;
    logic [CW-1:0]    cnt_r,       cnt_s;
    logic             a_msb_r,     a_msb_s;
    logic             b_msb_r,     b_msb_s;
    logic             in_ready_r,  in_ready_s;
    logic             out_valid_r, out_valid_s;
    logic [WIDTH-1:0] d_r,         d_s;
    logic             bout_r,      bout_s;
    logic             ovf_r,       ovf_s;
    logic [1:0]       bit_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_s     = state_r;
        a_sr_s      = a_sr_r;
        b_sr_s      = b_sr_r;
        res_sr_s    = res_sr_r;
        borrow_s    = borrow_r;
        cnt_s       = cnt_r;
        a_msb_s     = a_msb_r;
        b_msb_s     = b_msb_r;
        in_ready_s  = in_ready_r;
        out_valid_s = out_valid_r;
        d_s         = d_r;
        bout_s      = bout_r;
        ovf_s       = ovf_r;
        bit_s       = sub_bit(a_sr_r[0], b_sr_r[0], borrow_r);

        case (state_r)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    a_sr_s     = bus.A;
                    b_sr_s     = bus.B;
                    borrow_s   = bus.Bin;
                    a_msb_s    = bus.A[WIDTH-1];
                    b_msb_s    = bus.B[WIDTH-1];
                    cnt_s      = '0;
                    in_ready_s = 1'b0;
                    state_s    = SHIFT;
                end else begin
                    in_ready_s = 1'b1;
                    state_s    = IDLE;
                end
            end
            SHIFT: begin
                // Difference bits enter at the MSB so the first one ends at bit 0
                res_sr_s = {bit_s[0], res_sr_r[WIDTH-1:1]};
                a_sr_s   = {1'b0, a_sr_r[WIDTH-1:1]};
                b_sr_s   = {1'b0, b_sr_r[WIDTH-1:1]};
                borrow_s = bit_s[1];
                cnt_s    = cnt_r + CW'(1);
                if (cnt_r == LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (!out_valid_r) begin
                    // First DONE cycle publishes the result; it then holds until taken
                    d_s         = res_sr_r;
                    bout_s      = borrow_r;
                    ovf_s       = (a_msb_r != b_msb_r) && (res_sr_r[WIDTH-1] != a_msb_r);
                    out_valid_s = 1'b1;
                    state_s     = DONE;
                end else if (bus.out_ready) begin
                    out_valid_s = 1'b0;
                    in_ready_s  = 1'b1;
                    state_s     = IDLE;
                end else begin
                    state_s     = DONE;
                end
            end
            default: begin
                state_s     = IDLE;
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r      <= '0;
            b_sr_r      <= '0;
            res_sr_r    <= '0;
            borrow_r    <= 1'b0;
            cnt_r       <= '0;
            a_msb_r     <= 1'b0;
            b_msb_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            d_r         <= '0;
            bout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            a_sr_r      <= a_sr_s;
            b_sr_r      <= b_sr_s;
            res_sr_r    <= res_sr_s;
            borrow_r    <= borrow_s;
            cnt_r       <= cnt_s;
            a_msb_r     <= a_msb_s;
            b_msb_r     <= b_msb_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            d_r         <= d_s;
            bout_r      <= bout_s;
            ovf_r       <= ovf_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.D         = d_r;
    assign bus.Bout      = bout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed vectors with literal expectations,
// an arithmetic reference model with a scoreboard, a WIDTH=4 sweep and a WIDTH=8 run.
module tb_serial_sub;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(4)) bus4 ();
    serial_sub_if #(.WIDTH(8)) bus8 ();

    serial_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    // Reference: plain integer arithmetic, returns {ovf, bout, d[7:0]}
    function automatic logic [9:0] model(int w, int a, int b, int bin);
        int m, h, d, sa, sb, r;
        logic bo, ov;
        m  = 1 << w;
        h  = m >> 1;
        d  = ((a - b - bin) + 2 * m) % m;
        bo = (a < b + bin);
        sa = (a >= h) ? a - m : a;
        sb = (b >= h) ? b - m : b;
        r  = sa - sb - bin;
        ov = (r < -h) || (r > h - 1);
        return {ov, bo, 8'(d)};
    endfunction

    logic [9:0] exp_q[$];
    logic [9:0] e4;

    // Scoreboard: every cycle a WIDTH=4 result is presented it must match the oldest accept
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus4.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e4 = exp_q[0];
                    check("sb_D", int'(bus4.D), int'(e4[7:0]));
                    check("sb_Bout", int'(bus4.Bout), int'(e4[8]));
                    check("sb_ovf", int'(bus4.ovf), int'(e4[9]));
                    check("sb_in_ready_low", int'(bus4.in_ready), 0);
                    if (bus4.out_ready) void'(exp_q.pop_front());
                end
            end
            if (bus4.in_valid && bus4.in_ready)
                exp_q.push_back(model(4, int'(bus4.A), int'(bus4.B), int'(bus4.Bin)));
        end
    end

    task automatic send4(int a, int b, int bin);
        int n = 0;
        bus4.A = 4'(a);
        bus4.B = 4'(b);
        bus4.Bin = 1'(bin);
        bus4.in_valid = 1'b1;
        @(negedge clk);
        while (!bus4.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1 bus4.in_valid = 1'b0;
    endtask

    task automatic wait_out4();
        int n = 0;
        while (!bus4.out_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 50) check("out_valid_timeout", 0, 1);
    endtask

    task automatic recv4(int delay);
        wait_out4();
        if (delay > 0) begin
            bus4.out_ready = 1'b0;
            repeat (delay) begin
                @(posedge clk);
                #1;
            end
        end
        bus4.out_ready = 1'b1;
        @(posedge clk);
        #1 bus4.out_ready = 1'b0;
    endtask

    task automatic directed(int a, int b, int bin, int ed, int eb, int eo);
        bus4.out_ready = 1'b0;
        send4(a, b, bin);
        wait_out4();
        check("dir_D", int'(bus4.D), ed);
        check("dir_Bout", int'(bus4.Bout), eb);
        check("dir_ovf", int'(bus4.ovf), eo);
        recv4(0);
    endtask

    initial begin
        logic [9:0] e8;
        int a, b, bin, n;
        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Bin = 1'b0; bus4.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Bin = 1'b0; bus8.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(bus4.in_ready), 1);
        check("rst_out_valid", int'(bus4.out_valid), 0);
        check("rst_D", int'(bus4.D), 0);
        check("rst_Bout", int'(bus4.Bout), 0);
        check("rst_ovf", int'(bus4.ovf), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: accept at edge N, out_valid visible after edge N+5
        bus4.A = 4'd3; bus4.B = 4'd5; bus4.Bin = 1'b0; bus4.in_valid = 1'b1;
        @(posedge clk);
        #1 bus4.in_valid = 1'b0;
        check("accept_in_ready_low", int'(bus4.in_ready), 0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1 check("latency_out_valid", int'(bus4.out_valid), (k == 5) ? 1 : 0);
        end
        check("lat_D", int'(bus4.D), 14);
        check("lat_Bout", int'(bus4.Bout), 1);
        check("lat_ovf", int'(bus4.ovf), 0);

        // Backpressure with noisy inputs
        for (int k = 0; k < 10; k++) begin
            bus4.A = 4'($urandom_range(0, 15));
            bus4.B = 4'($urandom_range(0, 15));
            bus4.in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("stall_out_valid", int'(bus4.out_valid), 1);
            check("stall_in_ready", int'(bus4.in_ready), 0);
            check("stall_D", int'(bus4.D), 14);
            check("stall_Bout", int'(bus4.Bout), 1);
            check("stall_ovf", int'(bus4.ovf), 0);
        end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        @(posedge clk);
        #1 bus4.out_ready = 1'b0;
        check("release_out_valid", int'(bus4.out_valid), 0);
        check("release_in_ready", int'(bus4.in_ready), 1);
        check("release_D_held", int'(bus4.D), 14);

        directed(9, 5, 0, 4, 0, 1);
        directed(7, 15, 0, 8, 1, 1);
        directed(15, 15, 0, 0, 0, 0);
        directed(0, 0, 1, 15, 1, 0);

        // Reset two cycles into SHIFT aborts without emitting a result
        send4(12, 3, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_in_ready", int'(bus4.in_ready), 1);
        check("abort_out_valid", int'(bus4.out_valid), 0);
        check("abort_D", int'(bus4.D), 0);
        check("abort_Bout", int'(bus4.Bout), 0);
        check("abort_ovf", int'(bus4.ovf), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        directed(12, 3, 0, 9, 0, 0);

        // Full WIDTH=4 sweep with random ready/idle gaps
        for (int i = 0; i < 512; i++) begin
            bus4.out_ready = 1'($urandom_range(0, 1));
            send4(i[7:4], i[3:0], i[8]);
            recv4($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // WIDTH=8 random vectors
        for (int i = 0; i < 1000; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            bin = $urandom_range(0, 1);
            e8 = model(8, a, b, bin);
            bus8.A = 8'(a); bus8.B = 8'(b); bus8.Bin = 1'(bin); bus8.in_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus8.in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) check("w8_in_ready_timeout", 0, 1);
            @(posedge clk);
            #1 bus8.in_valid = 1'b0;
            n = 0;
            while (!bus8.out_valid && n < 50) begin
                @(posedge clk);
                #1 n++;
            end
            if (n >= 50) check("w8_out_valid_timeout", 0, 1);
            check("w8_D", int'(bus8.D), int'(e8[7:0]));
            check("w8_Bout", int'(bus8.Bout), int'(e8[8]));
            check("w8_ovf", int'(bus8.ovf), int'(e8[9]));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1 bus8.out_ready = 1'b1;
            @(posedge clk);
            #1 bus8.out_ready = 1'b0;
            check("w8_out_valid_drop", int'(bus8.out_valid), 0);
        end

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
